conv_mac3x3: RTL and testbench

//  3x3 multiply-accumulate engine of the conv layer; sits directly downstream of the kernel loader.

---
 rtl/conv_mac3x3.sv | 114 +++++++++++
 tb/tb_conv_mac3x3.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/conv_mac3x3.sv
// Three-stage 3x3 multiply-accumulate: products, adder tree, channel accumulator.
// Optional macro CONV_RELU_EN clamps negative results on the output register only.
module conv_mac3x3 #(
    parameter int DW    = 8,
    parameter int IN_CH = 8,
    parameter int ACC_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                in_valid,
    input  logic [9*DW-1:0]     win_flat,
    input  logic [9*DW-1:0]     kern_flat,
    output logic [3:0]          ch_idx,
    output logic                out_valid,
    output logic [ACC_W-1:0]    out_data
);

    localparam int PW = 2 * DW;
    localparam int SW = 2 * DW + 4;
    localparam logic [3:0] LAST_CH = 4'(IN_CH - 1);

    logic signed [PW-1:0]    prod_d [9];
    logic signed [PW-1:0]    prod_q [9];
    logic                    v1_q;
    logic signed [SW-1:0]    sum_d;
    logic signed [SW-1:0]    sum_q;
    logic                    v2_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] emit_d;
    logic [3:0]              ch_cnt_q;
    logic [3:0]              ch_idx_q;
    logic [3:0]              ch_idx_d;
    logic                    out_valid_q;
    logic [ACC_W-1:0]        out_data_q;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_mul
            assign prod_d[gi] = $signed(win_flat[gi*DW +: DW]) * $signed(kern_flat[gi*DW +: DW]);
        end
    endgenerate

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < 9; i++) begin
            sum_d = sum_d + SW'(prod_q[i]);
        end
    end

    // First channel of a group overwrites the accumulator instead of adding.
    always_comb begin
        acc_d = (ch_cnt_q == 4'd0) ? ACC_W'(sum_q) : acc_q + ACC_W'(sum_q);
`ifdef CONV_RELU_EN
        emit_d = acc_d[ACC_W-1] ? '0 : acc_d;
`else
        emit_d = acc_d;
`endif
    end

    assign ch_idx_d = (ch_idx_q == LAST_CH) ? 4'd0 : ch_idx_q + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                prod_q[i] <= '0;
            end
            v1_q        <= 1'b0;
            sum_q       <= '0;
            v2_q        <= 1'b0;
            acc_q       <= '0;
            ch_cnt_q    <= '0;
            ch_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (clr) begin
            // Flush in-flight beats; acc and out_data are intentionally kept.
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            ch_cnt_q    <= '0;
            ch_idx_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= 1'b0;
            if (in_valid) begin
                for (int i = 0; i < 9; i++) begin
                    prod_q[i] <= prod_d[i];
                end
                ch_idx_q <= ch_idx_d;
            end
            if (v1_q) begin
                sum_q <= sum_d;
            end
            if (v2_q) begin
                acc_q <= acc_d;
                if (ch_cnt_q == LAST_CH) begin
                    ch_cnt_q    <= 4'd0;
                    out_valid_q <= 1'b1;
                    out_data_q  <= emit_d;
                end else begin
                    ch_cnt_q <= ch_cnt_q + 4'd1;
                end
            end
        end
    end

    assign ch_idx    = ch_idx_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv_mac3x3.sv
// Directed bench for conv_mac3x3 (DW=8, IN_CH=8, ACC_W=24).
module tb_conv_mac3x3;

    localparam int DW    = 8;
    localparam int IN_CH = 8;
    localparam int ACC_W = 24;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 clr = 1'b0;
    logic                 in_valid = 1'b0;
    logic [9*DW-1:0]      win_flat = '0;
    logic [9*DW-1:0]      kern_flat = '0;
    logic [3:0]           ch_idx;
    logic                 out_valid;
    logic [ACC_W-1:0]     out_data;

    int n_pass = 0;
    int n_total = 0;
    int pulse_cnt = 0;
    int pulse_data [$];

    conv_mac3x3 #(.DW(DW), .IN_CH(IN_CH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .win_flat  (win_flat),
        .kern_flat (kern_flat),
        .ch_idx    (ch_idx),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) begin
            n_pass++;
            $display("check %-22s got=%0d exp=%0d ok", tag, got, exp);
        end else begin
            $display("FAIL %-22s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
        if (out_valid) begin
            pulse_cnt++;
            pulse_data.push_back(int'($signed(out_data)));
        end
    endtask

    task automatic beat(input logic signed [DW-1:0] p, input logic signed [DW-1:0] k);
        in_valid  = 1'b1;
        win_flat  = {9{p}};
        kern_flat = {9{k}};
        step();
        in_valid  = 1'b0;
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic group(input logic signed [DW-1:0] p, input logic signed [DW-1:0] k);
        for (int i = 0; i < IN_CH; i++) beat(p, k);
    endtask

    initial begin
        // Reset state
        #1;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_data", int'($signed(out_data)), 0);
        chk("reset ch_idx", int'(ch_idx), 0);
        #20;
        rst = 1'b0;
        flush(1);

        // All ones: check exact latency and one-cycle pulse
        pulse_cnt = 0;
        pulse_data.delete();
        group(8'sd1, 8'sd1);
        step();
        chk("ones early out_valid", int'(out_valid), 0);
        step();
        chk("ones out_valid", int'(out_valid), 1);
        chk("ones out_data", int'($signed(out_data)), 72);
        step();
        chk("ones pulse width", int'(out_valid), 0);
        chk("ones data held", int'($signed(out_data)), 72);
        flush(3);
        chk("ones pulse count", pulse_cnt, 1);

        // Largest magnitude products
        pulse_cnt = 0;
        pulse_data.delete();
        group(-8'sd128, -8'sd128);
        flush(4);
        chk("maxmag pulse count", pulse_cnt, 1);
        chk("maxmag out_data", int'($signed(out_data)), 1179648);

        // Negative result
        pulse_cnt = 0;
        pulse_data.delete();
        group(8'sd1, -8'sd2);
        flush(4);
        chk("neg pulse count", pulse_cnt, 1);
`ifdef CONV_RELU_EN
        chk("neg out_data relu", int'($signed(out_data)), 0);
`else
        chk("neg out_data", int'($signed(out_data)), -144);
`endif

        // Back-to-back groups: pulses exactly IN_CH cycles apart
        pulse_cnt = 0;
        pulse_data.delete();
        group(8'sd1, 8'sd2);
        group(8'sd1, 8'sd3);
        flush(4);
        chk("b2b pulse count", pulse_cnt, 2);
        if (pulse_data.size() == 2) begin
            chk("b2b data 0", pulse_data[0], 144);
            chk("b2b data 1", pulse_data[1], 216);
        end

        // clr coincident with beat 4 drops the partial group
        pulse_cnt = 0;
        pulse_data.delete();
        for (int i = 0; i < 3; i++) beat(8'sd5, 8'sd5);
        clr = 1'b1;
        beat(8'sd7, 8'sd7);
        clr = 1'b0;
        chk("clr ch_idx", int'(ch_idx), 0);
        group(8'sd1, 8'sd1);
        flush(4);
        chk("clr pulse count", pulse_cnt, 1);
        chk("clr out_data", int'($signed(out_data)), 72);

        // Gapped beats: ch_idx sequence and two results
        pulse_cnt = 0;
        pulse_data.delete();
        for (int i = 0; i < 2 * IN_CH; i++) begin
            chk($sformatf("gap ch_idx beat%0d", i), int'(ch_idx), i % IN_CH);
            beat(8'sd2, 8'sd3);
            flush((i * 3) % 4);
        end
        flush(4);
        chk("gap pulse count", pulse_cnt, 2);
        if (pulse_data.size() == 2) begin
            chk("gap data 0", pulse_data[0], 432);
            chk("gap data 1", pulse_data[1], 432);
        end

        // Async reset mid-group acts without a clock edge
        for (int i = 0; i < 3; i++) beat(8'sd4, 8'sd4);
        #1;
        rst = 1'b1;
        #1;
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst out_data", int'($signed(out_data)), 0);
        chk("rst ch_idx", int'(ch_idx), 0);
        #1;
        rst = 1'b0;
        pulse_cnt = 0;
        pulse_data.delete();
        group(8'sd1, 8'sd1);
        flush(4);
        chk("post rst pulse count", pulse_cnt, 1);
        chk("post rst out_data", int'($signed(out_data)), 72);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
